keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Sequencing controller between the keypad scanner (value/trig) and downstream consumers.
- Turns raw key events into an edited multi-digit entry: digit append, backspace, clear, enter.
- Drives the live display buffer.
- Presents each committed number over a valid/ready handshake.
- Replaces the free-running shift register with a state-machine-controlled buffer.

Parameters:
DIGITS, 4, number of BCD digits held in the entry buffer (1..8)
TIMEOUT_CYCLES, 50_000_000, idle clocks in ENTRY before auto-clear (used only with the optional feature)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
key_value  input  4  key code from keypad scanner, valid while key_trig high
key_trig  input  1  key-pressed level from scanner, synchronous to clk
disp  output  DIGITS*4  live entry buffer, newest digit in [3:0]
disp_count  output  $clog2(DIGITS+1)  digits currently entered
out_data  output  DIGITS*4  committed number, stable while out_valid
out_count  output  $clog2(DIGITS+1)  digit count of committed number
out_valid  output  1  committed number available
out_ready  input  1  consumer accepts out_data
overflow  output  1  one-cycle pulse: digit rejected because buffer full
busy  output  1  high in COMMIT; keys are ignored

Behaviour:
- Key event: key_trig=1 and trig_q=0, where trig_q is key_trig registered. A held key gives one event.
- All effects of an event are registered on the same clk edge, so disp updates one cycle after the edge sample.
- Key codes:
  - 0x0-0x9: digit.
  - 0xA: ENTER.
  - 0xB: BACKSPACE.
  - 0xC: CLEAR.
  - 0xD-0xF: ignored, no state change.
- Reset values: disp=0, disp_count=0, out_data=0, out_count=0, out_valid=0, overflow=0, busy=0, trig_q=0, state=IDLE.
- States: IDLE, ENTRY, COMMIT.
- IDLE (disp_count=0):
  - Digit: disp={disp[..]<<4 | d}, count=1, go to ENTRY.
  - ENTER, BACKSPACE, CLEAR: no effect.
- ENTRY:
  - Digit with count<DIGITS: shift left 4, insert d at [3:0], count+1.
  - Digit with count==DIGITS: buffer unchanged, overflow=1 for one cycle.
  - BACKSPACE: disp=disp>>4 (zero fill at top), count-1; go to IDLE if count becomes 0.
  - CLEAR: disp=0, count=0, go to IDLE.
  - ENTER: out_data<=disp, out_count<=disp_count, out_valid<=1, busy<=1, go to COMMIT. disp holds its value.
- COMMIT:
  - out_valid and out_data are held until out_ready=1.
  - On the cycle out_valid&&out_ready: out_valid<=0, busy<=0, disp<=0, count<=0, go to IDLE.
  - All key events in COMMIT are dropped, including CLEAR, even when coincident with the handshake.
  - out_ready while out_valid=0 has no effect.
- Width rules: disp_count never exceeds DIGITS and never underflows. Shifts discard bits beyond DIGITS*4.
- Reset mid-operation, including COMMIT with out_valid=1: immediate return to reset values. The pending number is lost.
- Event latched on the edge reset deasserts: ignored, because trig_q=0 forces edge detection on the first cycle. A key held through reset therefore produces one event after release of reset.

Optional Feature:
Macro KEYPAD_ENTRY_TIMEOUT_EN.
- Defined:
  - Counter of $clog2(TIMEOUT_CYCLES+1) bits runs in ENTRY only.
  - It is cleared on every key event and on leaving ENTRY.
  - When it reaches TIMEOUT_CYCLES-1 with no event: behave as CLEAR (disp=0, count=0, IDLE) on the next edge.
  - A key event on the same cycle as expiry wins, and the counter restarts.
  - Counter inactive in IDLE and COMMIT.
- Undefined: no counter logic; ENTRY persists indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
1. DIGITS=4: keys 1,2,3 then ENTER, out_ready=0 for 5 cycles then 1 -> disp=0x0123, count 3. out_valid high 5 cycles with out_data=0x0123, out_count=3, busy=1. After handshake: disp=0, count=0, IDLE.
2. Keys 9,8,7,6,5 -> disp=0x9876. The fifth key gives a single-cycle overflow pulse. count stays 4.
3. Keys 4,5, BACKSPACE, 7, then CLEAR -> disp 0x0045, then 0x0004, then 0x0047, then 0x0000 with count 0 and IDLE. ENTER in IDLE leaves out_valid=0.
4. key_trig held high 20 cycles with value 0x3, keys 0xD/0xE, and keys during COMMIT -> exactly one digit appended; 0xD/0xE cause no change. COMMIT keys do not alter out_data or disp, including a key coincident with out_ready.
5. Reset asserted mid-COMMIT with out_valid=1 -> all outputs 0 immediately (asynchronous, before the next clk). The first key after release works normally.
6. With KEYPAD_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=10: key 5, then idle -> disp=0 after exactly 10 idle cycles. A key at cycle 9 restarts the count and the buffer keeps 0x0055.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: edits a BCD entry buffer from key events and
// presents committed numbers over valid/ready. Optional idle auto-clear: KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry_ctrl #(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   key_value,
    input  logic                         key_trig,
    output logic [DIGITS*4-1:0]          disp,
    output logic [$clog2(DIGITS+1)-1:0]  disp_count,
    output logic [DIGITS*4-1:0]          out_data,
    output logic [$clog2(DIGITS+1)-1:0]  out_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic                         busy,
    output logic [1:0]                   fsm_state
);

    localparam int W  = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ENTRY  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    logic [1:0]   state;
    logic         trig_q;
    logic         key_event;
    logic         is_digit;
    logic         full;
    logic         timeout;
    logic [W-1:0] disp_shl;

    // A held key produces exactly one event; trig_q resets low so a key held
    // through reset yields one event on the first cycle after release.
    assign key_event = key_trig && !trig_q;
    assign is_digit  = (key_value <= 4'd9);
    assign full      = (disp_count == CNT_MAX);
    assign disp_shl  = (disp << 4) | W'(key_value);
    assign fsm_state = state;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // Expiry is suppressed by a coincident key event; the event restarts the count.
    assign timeout = (state == ENTRY) && !key_event &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != ENTRY || key_event || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Output handshake: out_data/out_count are held stable while out_valid is
    // high; a transfer occurs on any rising edge where out_valid && out_ready.
    // out_ready without out_valid is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            trig_q     <= 1'b0;
            disp       <= '0;
            disp_count <= '0;
            out_data   <= '0;
            out_count  <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            trig_q   <= key_trig;
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_event && is_digit) begin
                        disp       <= disp_shl;
                        disp_count <= CNT_ONE;
                        state      <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (key_event) begin
                        if (is_digit) begin
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                disp       <= disp_shl;
                                disp_count <= disp_count + CNT_ONE;
                            end
                        end else begin
                            case (key_value)
                                KEY_ENTER: begin
                                    out_data  <= disp;
                                    out_count <= disp_count;
                                    out_valid <= 1'b1;
                                    busy      <= 1'b1;
                                    state     <= COMMIT;
                                end
                                KEY_BACK: begin
                                    disp       <= disp >> 4;
                                    disp_count <= disp_count - CNT_ONE;
                                    if (disp_count == CNT_ONE) begin
                                        state <= IDLE;
                                    end
                                end
                                KEY_CLEAR: begin
                                    disp       <= '0;
                                    disp_count <= '0;
                                    state      <= IDLE;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end else if (timeout) begin
                        disp       <= '0;
                        disp_count <= '0;
                        state      <= IDLE;
                    end
                end
                COMMIT: begin
                    // Keys are dropped here, even one coincident with the transfer.
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        busy       <= 1'b0;
                        disp       <= '0;
                        disp_count <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl (DIGITS=4); committed numbers go
// through an expected queue and are compared at each transfer.
module tb_keypad_entry_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = DIGITS * 4;
    localparam int CW     = $clog2(DIGITS + 1);
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int TO_CYC = 10;
`else
    localparam int TO_CYC = 50_000_000;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENTRY  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic          clk;
    logic          reset;
    logic [3:0]    key_value;
    logic          key_trig;
    logic [W-1:0]  disp;
    logic [CW-1:0] disp_count;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          busy;
    logic [1:0]    fsm_state;

    logic [W+CW-1:0] exp_q[$];

    int errors;
    int checks;

    keypad_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset), .key_value(key_value), .key_trig(key_trig),
        .disp(disp), .disp_count(disp_count), .out_data(out_data),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .busy(busy), .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic press(input logic [3:0] v);
        @(negedge clk);
        key_value = v;
        key_trig  = 1'b1;
        @(negedge clk);
        key_trig  = 1'b0;
    endtask

    task automatic check_entry(input string name, input logic [W-1:0] ed,
                               input logic [CW-1:0] ec, input logic [1:0] es);
        checks++;
        if (disp !== ed || disp_count !== ec || fsm_state !== es) begin
            errors++;
            $display("FAIL %s: got disp=%h cnt=%0d st=%0d want disp=%h cnt=%0d st=%0d",
                     name, disp, disp_count, fsm_state, ed, ec, es);
        end
    endtask

    task automatic enter_and_push(input logic [W-1:0] ed, input logic [CW-1:0] ec);
        press(4'hA);
        exp_q.push_back({ec, ed});
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || fsm_state !== S_COMMIT) begin
            errors++;
            $display("FAIL enter: got valid=%b busy=%b st=%0d want 1 1 2",
                     out_valid, busy, fsm_state);
        end
    endtask

    // scoreboard pop: called at a negedge; transfer happens on next posedge
    task automatic accept(input string name);
        logic [W+CW-1:0] e;
        int budget;
        budget = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b want 1", name, out_valid);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got data=%h cnt=%0d want no output",
                     name, out_data, out_count);
        end else begin
            e = exp_q.pop_front();
            if ({out_count, out_data} !== e) begin
                errors++;
                $display("FAIL %s_data: got data=%h cnt=%0d want data=%h cnt=%0d",
                         name, out_data, out_count, e[W-1:0], e[W+CW-1:W]);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
        check_entry({name, "_after"}, '0, '0, S_IDLE);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_value = 4'h0;
        key_trig = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (disp !== '0 || disp_count !== '0 || out_data !== '0 || out_count !== '0 ||
            out_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_values: got disp=%h cnt=%0d od=%h oc=%0d v=%b ov=%b b=%b st=%0d want all 0",
                     disp, disp_count, out_data, out_count, out_valid, overflow, busy, fsm_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_commit();
        press(4'h1);
        check_entry("t1_k1", 16'h0001, 3'd1, S_ENTRY);
        press(4'h2);
        press(4'h3);
        check_entry("t1_k3", 16'h0123, 3'd3, S_ENTRY);
        enter_and_push(16'h0123, 3'd3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0123 || out_count !== 3'd3 ||
                busy !== 1'b1 || disp !== 16'h0123) begin
                errors++;
                $display("FAIL t1_hold%0d: got v=%b od=%h oc=%0d b=%b disp=%h want 1 0123 3 1 0123",
                         i, out_valid, out_data, out_count, busy, disp);
            end
            @(negedge clk);
        end
        accept("t1_hs");
    endtask

    task automatic test_overflow();
        press(4'h9);
        press(4'h8);
        press(4'h7);
        press(4'h6);
        check_entry("t2_full", 16'h9876, 3'd4, S_ENTRY);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL t2_no_ovf: got %b want 0", overflow);
        end
        press(4'h5);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL t2_ovf_pulse: got %b want 1", overflow);
        end
        check_entry("t2_kept", 16'h9876, 3'd4, S_ENTRY);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL t2_ovf_single: got %b want 0", overflow);
        end
        press(4'hC);
        check_entry("t2_clear", '0, '0, S_IDLE);
    endtask

    task automatic test_edit();
        press(4'h4);
        press(4'h5);
        check_entry("t3_45", 16'h0045, 3'd2, S_ENTRY);
        press(4'hB);
        check_entry("t3_bs", 16'h0004, 3'd1, S_ENTRY);
        press(4'h7);
        check_entry("t3_47", 16'h0047, 3'd2, S_ENTRY);
        press(4'hC);
        check_entry("t3_clr", 16'h0000, 3'd0, S_IDLE);
        press(4'hA);
        press(4'hB);
        press(4'hC);
        checks++;
        if (out_valid !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL t3_idle_enter: got v=%b st=%0d want 0 0", out_valid, fsm_state);
        end
        press(4'h9);
        press(4'hB);
        check_entry("t3_bs_to_idle", '0, '0, S_IDLE);
    endtask

    task automatic test_ignored_keys();
        @(negedge clk);
        key_value = 4'h3;
        key_trig  = 1'b1;
        repeat (20) @(negedge clk);
        key_trig  = 1'b0;
        check_entry("t4_held", 16'h0003, 3'd1, S_ENTRY);
        press(4'hD);
        press(4'hE);
        press(4'hF);
        check_entry("t4_ignored", 16'h0003, 3'd1, S_ENTRY);
        enter_and_push(16'h0003, 3'd1);
        press(4'h5);
        press(4'hC);
        press(4'hB);
        checks++;
        if (out_data !== 16'h0003 || out_count !== 3'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t4_commit_keys: got od=%h oc=%0d v=%b want 0003 1 1",
                     out_data, out_count, out_valid);
        end
        check_entry("t4_commit_disp", 16'h0003, 3'd1, S_COMMIT);
        // key event coincident with the transfer edge
        key_value = 4'h7;
        key_trig  = 1'b1;
        accept("t4_hs");
        key_trig  = 1'b0;
        @(negedge clk);
        check_entry("t4_dropped", '0, '0, S_IDLE);
    endtask

    task automatic test_reset_mid_commit();
        press(4'h2);
        enter_and_push(16'h0002, 3'd1);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (disp !== '0 || disp_count !== '0 || out_data !== '0 || out_count !== '0 ||
            out_valid !== 1'b0 || busy !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL t5_async_reset: got disp=%h od=%h v=%b b=%b st=%0d want all 0",
                     disp, out_data, out_valid, busy, fsm_state);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        press(4'h8);
        check_entry("t5_after", 16'h0008, 3'd1, S_ENTRY);
        press(4'h1);
        enter_and_push(16'h0081, 3'd2);
        accept("t5_hs");
    endtask

    task automatic test_back_to_back();
        logic [3:0]    d;
        logic [W-1:0]  m;
        logic [CW-1:0] c;
        for (int n = 0; n < 3; n++) begin
            m = '0;
            c = '0;
            for (int k = 0; k < n + 2; k++) begin
                d = 4'($urandom_range(0, 9));
                press(d);
                m = (m << 4) | W'(d);
                c = c + CW'(1);
            end
            check_entry("b2b_entry", m, c, S_ENTRY);
            enter_and_push(m, c);
            accept("b2b_hs");
        end
    endtask

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    task automatic test_timeout();
        press(4'h5);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            check_entry("t6_wait", 16'h0005, 3'd1, S_ENTRY);
        end
        @(negedge clk);
        check_entry("t6_expired", '0, '0, S_IDLE);
        press(4'h5);
        repeat (9) @(negedge clk);
        key_value = 4'h5;
        key_trig  = 1'b1;
        @(negedge clk);
        key_trig  = 1'b0;
        check_entry("t6_event_wins", 16'h0055, 3'd2, S_ENTRY);
        repeat (9) @(negedge clk);
        check_entry("t6_restarted", 16'h0055, 3'd2, S_ENTRY);
        @(negedge clk);
        check_entry("t6_expired2", '0, '0, S_IDLE);
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_commit();
        test_overflow();
        test_edit();
        test_ignored_keys();
        test_reset_mid_commit();
        test_back_to_back();
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
